// File: rtl/mem_responder.sv
// mem_responder: word memory with fixed-latency reads and a one-cycle done pulse.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned requests with err.
module mem_responder #(
  parameter int DEPTH_WORDS  = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memWriteOrRead,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic [1:0]  estado
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, READ_WAIT, READ_DONE, WRITE_DONE} state_t;
  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   rdata_q;
  logic          done_q, busy_q, err_q;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          misaligned, wr_en, unused_addr;
  assign idx = address[AW+1:2];
  assign unused_addr = ^{address[31:AW+2], address[1:0]};
`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = |address[1:0];
`else
  assign misaligned = 1'b0;
`endif
  // reset in the enable drops a write accepted while reset is asserted
  assign wr_en = reset && state_q == IDLE && req && memWriteOrRead && !misaligned;
  always_ff @(posedge clk)
    if (wr_en) mem[idx] <= wdata;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (req) begin
          if (misaligned || memWriteOrRead) begin
            state_q <= WRITE_DONE;
            done_q  <= 1'b1;
            err_q   <= misaligned;
          end else begin
            idx_q <= idx;
            cnt_q <= 4'(READ_LATENCY - 1);
            if (READ_LATENCY == 1) begin
              state_q <= READ_DONE;
              rdata_q <= mem[idx];
              done_q  <= 1'b1;
            end else begin
              state_q <= READ_WAIT;
              busy_q  <= 1'b1;
            end
          end
        end
        READ_WAIT: if (cnt_q == 4'd1) begin
          state_q <= READ_DONE;
          rdata_q <= mem[idx_q];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rdata  = rdata_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign err    = err_q;
  assign estado = state_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of latency, wrap, busy drop, reset abort and alignment.
module tb_mem_responder;
  localparam int LAT = 2;
  logic        clk = 1'b0, reset = 1'b0, req = 1'b0, wr = 1'b0;
  logic [31:0] address = 32'd0, wdata = 32'd0, rdata;
  logic        done, busy, err;
  logic [1:0]  estado;
  int errors = 0, checks = 0;
  mem_responder #(.DEPTH_WORDS(256), .READ_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .memWriteOrRead(wr), .address(address),
    .wdata(wdata), .rdata(rdata), .done(done), .busy(busy), .err(err), .estado(estado)
  );
  always #5 clk = ~clk;
  // tasks start and end just after a falling edge; outputs are sampled there
  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; wr = 1'b1; address = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
  endtask
  task automatic read_word(input logic [31:0] a, output logic [31:0] d, output int lat);
    req = 1'b1; wr = 1'b0; address = a;
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = rdata;
    @(negedge clk);
  endtask
  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rdata, done, busy, err, estado} !== 37'd0) begin
      errors++; $display("FAIL reset_hold: got rdata=%h done=%b busy=%b err=%b estado=%0d, want all 0", rdata, done, busy, err, estado);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rdata, done, busy, err, estado} !== 37'd0) begin
        errors++; $display("FAIL idle_%0d: got rdata=%h done=%b busy=%b err=%b estado=%0d, want all 0", i, rdata, done, busy, err, estado);
      end
    end
  endtask
  task automatic test_write_read;
    req = 1'b1; wr = 1'b1; address = 32'h10; wdata = 32'hDEADBEEF;
    @(negedge clk);
    req = 1'b0;
    checks++;
    if ({done, busy, err, estado} !== 5'b10011) begin
      errors++; $display("FAIL write_done: got done=%b busy=%b err=%b estado=%0d, want 1 0 0 3", done, busy, err, estado);
    end
    @(negedge clk);
    checks++;
    if ({done, estado, rdata} !== {1'b0, 2'd0, 32'd0}) begin
      errors++; $display("FAIL write_after: got done=%b estado=%0d rdata=%h, want 0 0 00000000", done, estado, rdata);
    end
    req = 1'b1; wr = 1'b0; address = 32'h10;
    @(negedge clk);
    req = 1'b0;
    checks++;
    if ({done, busy, estado} !== 4'b0101) begin
      errors++; $display("FAIL read_wait: got done=%b busy=%b estado=%0d, want 0 1 1", done, busy, estado);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, estado, rdata} !== {1'b1, 1'b0, 2'd2, 32'hDEADBEEF}) begin
      errors++; $display("FAIL read_done: got done=%b busy=%b estado=%0d rdata=%h, want 1 0 2 deadbeef", done, busy, estado, rdata);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, estado, rdata} !== {1'b0, 1'b0, 2'd0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL read_hold: got done=%b busy=%b estado=%0d rdata=%h, want 0 0 0 deadbeef", done, busy, estado, rdata);
    end
    write_word(32'h14, 32'h01020304);
    checks++;
    if (rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_keeps_rdata: got %h want deadbeef", rdata);
    end
  endtask
  task automatic test_wrap;
    logic [31:0] d;
    int lat;
    write_word(32'h400, 32'h12345678);
    read_word(32'h000, d, lat);
    checks++;
    if (d !== 32'h12345678 || lat != LAT) begin
      errors++; $display("FAIL wrap: got data=%h lat=%0d, want 12345678 lat=%0d", d, lat, LAT);
    end
  endtask
  task automatic test_busy_drop;
    logic [31:0] d;
    int lat;
    write_word(32'h20, 32'hCAFEF00D);
    req = 1'b1; wr = 1'b0; address = 32'h20;
    @(negedge clk);
    wr = 1'b1; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    checks++;
    if ({done, estado, rdata} !== {1'b1, 2'd2, 32'hCAFEF00D}) begin
      errors++; $display("FAIL busy_read_done: got done=%b estado=%0d rdata=%h, want 1 2 cafef00d", done, estado, rdata);
    end
    @(negedge clk);
    req = 1'b0;
    checks++;
    if ({done, estado} !== 3'b000) begin
      errors++; $display("FAIL done_cycle_req: got done=%b estado=%0d, want 0 0", done, estado);
    end
    read_word(32'h20, d, lat);
    checks++;
    if (d !== 32'hCAFEF00D) begin
      errors++; $display("FAIL busy_drop: got %h want cafef00d", d);
    end
  endtask
  task automatic test_reset_mid_read;
    logic [31:0] d;
    int lat;
    write_word(32'h30, 32'h5A5A1234);
    req = 1'b1; wr = 1'b0; address = 32'h30;
    @(negedge clk);
    req = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if ({rdata, done, busy, estado} !== 36'd0) begin
      errors++; $display("FAIL abort: got rdata=%h done=%b busy=%b estado=%0d, want all 0", rdata, done, busy, estado);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || rdata !== 32'd0) begin
        errors++; $display("FAIL abort_quiet_%0d: got done=%b rdata=%h, want 0 00000000", i, done, rdata);
      end
    end
    read_word(32'h30, d, lat);
    checks++;
    if (d !== 32'h5A5A1234 || lat != LAT) begin
      errors++; $display("FAIL post_reset_read: got %h lat=%0d, want 5a5a1234 lat=%0d", d, lat, LAT);
    end
  endtask
  task automatic test_reset_write;
    logic [31:0] d;
    int lat;
    write_word(32'h40, 32'h0BADC0DE);
    req = 1'b1; wr = 1'b1; address = 32'h40; wdata = 32'h00000077;
    reset = 1'b0;
    @(negedge clk);
    req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    read_word(32'h40, d, lat);
    checks++;
    if (d !== 32'h0BADC0DE) begin
      errors++; $display("FAIL reset_write: got %h want 0badc0de", d);
    end
  endtask
  task automatic test_align;
    logic [31:0] d, exp;
    int lat;
    write_word(32'h10, 32'h11112222);
    req = 1'b1; wr = 1'b1; address = 32'h13; wdata = 32'hAAAA5555;
    @(negedge clk);
    req = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    exp = 32'h11112222;
    checks++;
    if ({done, err, estado} !== 4'b1111) begin
      errors++; $display("FAIL align_err: got done=%b err=%b estado=%0d, want 1 1 3", done, err, estado);
    end
`else
    exp = 32'hAAAA5555;
    checks++;
    if ({done, err, estado} !== 4'b1011) begin
      errors++; $display("FAIL align_ignored: got done=%b err=%b estado=%0d, want 1 0 3", done, err, estado);
    end
`endif
    @(negedge clk);
    checks++;
    if ({done, err} !== 2'b00) begin
      errors++; $display("FAIL align_after: got done=%b err=%b, want 0 0", done, err);
    end
    read_word(32'h10, d, lat);
    checks++;
    if (d !== exp || err !== 1'b0) begin
      errors++; $display("FAIL align_read: got %h err=%b, want %h err=0", d, err, exp);
    end
  endtask
  initial begin
    test_reset;
    test_write_read;
    test_wrap;
    test_busy_drop;
    test_reset_mid_read;
    test_reset_write;
    test_align;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's memory interface.
- Accepts read/write requests issued by the control unit (memWriteOrRead, address, wdata), holds word storage, and returns read data after a fixed, parameterised latency with a one-cycle done pulse.
- Sits between the control unit / datapath address mux and the instruction/data register inputs.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; must be a power of two, 2..65536.
- READ_LATENCY, 2, cycles from request accept edge to done pulse on a read; legal 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  request strobe; sampled only in IDLE.
- memWriteOrRead  input  1  1 = write, 0 = read; sampled with req.
- address  input  32  byte address; word index = address[log2(DEPTH_WORDS)+1:2].
- wdata  input  32  write data; sampled with req.
- rdata  output  32  read data; updated only when a read completes.
- done  output  1  one-cycle pulse when a request completes.
- busy  output  1  high while a read is in flight; requests ignored while high.
- err  output  1  alignment error flag (see Optional Feature); constant 0 when the feature is absent.
- estado  output  2  current FSM state encoding, for debug.

Behaviour:
- Reset (reset = 0, asynchronous):
  - FSM to IDLE.
  - rdata = 0, done = 0, busy = 0, err = 0, estado = 0.
  - Latency counter cleared.
  - Storage contents NOT cleared; they are retained across reset.
- FSM states: IDLE(0), READ_WAIT(1), READ_DONE(2), WRITE_DONE(3).
- IDLE:
  - req = 1 and memWriteOrRead = 1: mem[idx] <= wdata at this edge; go to WRITE_DONE.
  - req = 1 and memWriteOrRead = 0: latch idx, load counter with READ_LATENCY-1.
    - READ_LATENCY = 1: go to READ_DONE.
    - Otherwise: go to READ_WAIT.
  - req = 0: stay in IDLE.
- READ_WAIT:
  - busy = 1.
  - Counter decrements each cycle; at counter = 1, go to READ_DONE.
- READ_DONE:
  - rdata <= mem[latched idx] at entry edge; done = 1 for this cycle; busy = 0.
  - Next state is IDLE.
- WRITE_DONE: done = 1 for one cycle, busy = 0; next state is IDLE.
- Latency: read done asserted exactly READ_LATENCY cycles after the accept edge; write done asserted 1 cycle after the accept edge.
- Address handling:
  - Upper address bits above the index are ignored, so access wraps modulo DEPTH_WORDS.
  - address[1:0] is ignored unless the feature is enabled.
- req in any non-IDLE state is dropped: no queueing, no side effect.
  - req must be re-presented in IDLE; done in the completing cycle does not accept a new request that same cycle.
- Read-after-write to the same index returns the newly written data.
- rdata holds its value between reads; writes never change rdata.
- Reset asserted mid-read aborts the read: no done pulse, rdata = 0, memory unchanged.
- Reset asserted in the same cycle as a write accept: the write is discarded.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A request with address[1:0] != 0 is rejected: no storage write, no rdata update.
  - FSM goes to WRITE_DONE (either direction) and pulses done with err = 1 for that cycle only.
  - err = 0 at all other times.
- Undefined:
  - address[1:0] is ignored; err is tied to 0.

Test Plan:
- Reset then idle: reset low 3 cycles, release -> rdata = 0, done = 0, busy = 0, estado = 0 for 5 idle cycles.
- Write then read: write 0xDEADBEEF @0x10, then read @0x10 with READ_LATENCY = 2 -> done 1 cycle after write accept; read done 2 cycles after accept; rdata = 0xDEADBEEF; busy high exactly 1 cycle.
- Wrap-around: DEPTH_WORDS = 256, write 0x12345678 @0x400, read @0x000 -> rdata = 0x12345678.
- Request while busy: read @0x20 accepted, write 0xFFFFFFFF @0x20 presented during READ_WAIT -> write ignored; a later read @0x20 returns the original value.
- Reset mid-read: read accepted, reset pulsed low during READ_WAIT -> no done, rdata = 0; a subsequent read returns the pre-reset stored data.
- MEM_ALIGN_CHECK_EN defined: write 0xAAAA5555 @0x13 -> done with err = 1, one cycle; read @0x10 returns the prior content. Undefined: same write stores to word 4, err = 0.
